// File: rtl/keccak_ctrl_pkg.sv
// Shared types and defaults for the Keccak round controller.
// Provides the FSM state enum, round index width and default parameters.
package keccak_ctrl_pkg;

  localparam int NUM_ROUNDS_DEF   = 24;
  localparam int ROUND_W          = 5;
  localparam int STEP_TIMEOUT_DEF = 64;

  typedef enum logic [3:0] {
    IDLE,
    PAR_S,
    PAR_W,
    ROT_S,
    ROT_W,
    PER_S,
    PER_W,
    REV_S,
    REV_W,
    RC_S,
    RC_W,
    DONE
`ifdef STEP_WDOG_EN
    ,
    ERR
`endif
  } state_t;

endpackage

// File: rtl/step_watchdog.sv
// Per-step wait counter: cleared while a step is being started, counts
// wait cycles; expired flags the cycle in which the TIMEOUT-th wait occurs.
// Ports: clk, rst (async active-low), clear, tick -> expired.
module step_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = tick && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/keccak_round_ctrl.sv
// Keccak round controller: sequences par/rot/per/rev/RC steps for
// NUM_ROUNDS rounds per message. Inputs: clk, rst (async active-low),
// start, ready_*, co. Outputs: start_*, cnt_up, busy, done, round, err.
// Optional step watchdog enabled by defining STEP_WDOG_EN.
module keccak_round_ctrl
  import keccak_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
`ifdef STEP_WDOG_EN
  ,
  parameter int STEP_TIMEOUT = STEP_TIMEOUT_DEF
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ready_par,
  input  logic               ready_rot,
  input  logic               ready_per,
  input  logic               ready_rev,
  input  logic               ready_RC,
  input  logic               co,
  output logic               start_par,
  output logic               start_rot,
  output logic               start_per,
  output logic               start_rev,
  output logic               start_RC,
  output logic               cnt_up,
  output logic               busy,
  output logic               done,
  output logic [ROUND_W-1:0] round,
  output logic               err
);

  state_t             state;
  logic [ROUND_W-1:0] next_round;

  assign next_round = (round == ROUND_W'(NUM_ROUNDS - 1))
                    ? '0 : round + 1'b1;

`ifdef STEP_WDOG_EN
  logic in_start;
  logic in_wait;
  logic step_ready;
  logic expired;
  logic timeout;

  always_comb begin
    in_start   = 1'b0;
    in_wait    = 1'b0;
    step_ready = 1'b0;
    case (state)
      PAR_S, ROT_S, PER_S, REV_S, RC_S: in_start = 1'b1;
      PAR_W: begin in_wait = 1'b1; step_ready = ready_par; end
      ROT_W: begin in_wait = 1'b1; step_ready = ready_rot; end
      PER_W: begin in_wait = 1'b1; step_ready = ready_per; end
      REV_W: begin in_wait = 1'b1; step_ready = ready_rev; end
      RC_W:  begin in_wait = 1'b1; step_ready = ready_RC;  end
      default: ;
    endcase
  end

  step_watchdog #(
    .TIMEOUT(STEP_TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (in_start),
    .tick   (in_wait),
    .expired(expired)
  );

  // A ready arriving in the last allowed cycle still wins.
  assign timeout = expired && !step_ready;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      start_par <= 1'b0;
      start_rot <= 1'b0;
      start_per <= 1'b0;
      start_rev <= 1'b0;
      start_RC  <= 1'b0;
      cnt_up    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      round     <= '0;
`ifdef STEP_WDOG_EN
      err       <= 1'b0;
`endif
    end else begin
      start_par <= 1'b0;
      start_rot <= 1'b0;
      start_per <= 1'b0;
      start_rev <= 1'b0;
      start_RC  <= 1'b0;
      cnt_up    <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= PAR_S;
          start_par <= 1'b1;
          busy      <= 1'b1;
`ifdef STEP_WDOG_EN
          err       <= 1'b0;
`endif
        end
        PAR_S: state <= PAR_W;
        PAR_W: if (ready_par) begin
          state     <= ROT_S;
          start_rot <= 1'b1;
        end
        ROT_S: state <= ROT_W;
        ROT_W: if (ready_rot) begin
          state     <= PER_S;
          start_per <= 1'b1;
        end
        PER_S: state <= PER_W;
        PER_W: if (ready_per) begin
          state     <= REV_S;
          start_rev <= 1'b1;
        end
        REV_S: state <= REV_W;
        REV_W: if (ready_rev) begin
          state    <= RC_S;
          start_RC <= 1'b1;
        end
        RC_S: state <= RC_W;
        RC_W: if (ready_RC) begin
          // Counter steps on the last round too, so it wraps to 0.
          cnt_up <= 1'b1;
          if (co) begin
            state <= DONE;
            done  <= 1'b1;
            round <= '0;
          end else begin
            state     <= PAR_S;
            start_par <= 1'b1;
            round     <= next_round;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`ifdef STEP_WDOG_EN
        ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
`ifdef STEP_WDOG_EN
      // Only reachable in a wait state without ready: no pulse pending.
      if (timeout) begin
        state <= ERR;
        err   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Testbench for keccak_round_ctrl: step responder with random delays,
// datapath round-counter model and protocol monitor.
module tb_keccak_round_ctrl;

  localparam int NR = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       ready_par = 1'b0;
  logic       ready_rot = 1'b0;
  logic       ready_per = 1'b0;
  logic       ready_rev = 1'b0;
  logic       ready_RC = 1'b0;
  logic       co = 1'b0;
  logic       start_par, start_rot, start_per;
  logic       start_rev, start_RC, cnt_up;
  logic       busy, done, err;
  logic [4:0] round;

  keccak_round_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .ready_par(ready_par), .ready_rot(ready_rot),
    .ready_per(ready_per), .ready_rev(ready_rev),
    .ready_RC(ready_RC), .co(co),
    .start_par(start_par), .start_rot(start_rot),
    .start_per(start_per), .start_rev(start_rev),
    .start_RC(start_RC), .cnt_up(cnt_up),
    .busy(busy), .done(done), .round(round), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int exp_step, exp_round, ctr;
  int n_start[5];
  int n_cntup, n_done, done_cyc, per_cyc;
  int order_err, rdy_err, round_err, cntup_err;
  int rdy_cyc[5];
  bit pend[5];
  int dly[5];
  int maxd = 0;
  bit first = 1'b1;
  bit hold_rot = 1'b0;
  bit block_per = 1'b0;

  task automatic clear_model(input bit with_ctr);
    for (int i = 0; i < 5; i++) begin
      n_start[i] = 0; rdy_cyc[i] = -100;
      pend[i] = 1'b0; dly[i] = 0;
    end
    exp_step = 0; exp_round = 0;
    n_cntup = 0; n_done = 0; done_cyc = -1; per_cyc = -1;
    order_err = 0; rdy_err = 0; round_err = 0; cntup_err = 0;
    first = 1'b1;
    if (with_ctr) ctr = 0;
  endtask

  // Monitor + responder: every step must follow its predecessor's ready
  // by exactly one cycle, in par/rot/per/rev/RC order.
  always @(negedge clk) begin
    logic [4:0] st;
    int s;
    st = {start_RC, start_rev, start_per, start_rot, start_par};
    if (st != 5'd0) begin
      if ($countones(st) != 1) order_err++;
      else begin
        s = 0;
        for (int i = 0; i < 5; i++) if (st[i]) s = i;
        if (s != exp_step) order_err++;
        if (s == 0 && first) first = 1'b0;
        else begin
          if (rdy_cyc[(s + 4) % 5] != cyc - 1) rdy_err++;
          if (s == 0) exp_round = (exp_round + 1) % NR;
        end
        if (s == 0 && round !== 5'(exp_round)) round_err++;
        if (s == 2) per_cyc = cyc;
        n_start[s]++;
        exp_step = (s + 1) % 5;
      end
    end
    if (cnt_up) begin
      n_cntup++;
      ctr = (ctr + 1) % NR;
      if (!(start_par || done)) cntup_err++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      if (rdy_cyc[4] != cyc - 1 || exp_step != 0) order_err++;
    end
    ready_par = 1'b0;
    ready_rot = hold_rot;
    ready_per = 1'b0;
    ready_rev = 1'b0;
    ready_RC  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (pend[i] && !(i == 2 && block_per)) begin
        if (dly[i] == 0) begin
          pend[i] = 1'b0;
          rdy_cyc[i] = cyc;
          case (i)
            0: ready_par = 1'b1;
            1: ready_rot = 1'b1;
            2: ready_per = 1'b1;
            3: ready_rev = 1'b1;
            default: ready_RC = 1'b1;
          endcase
        end else dly[i]--;
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (st[i]) begin
        pend[i] = 1'b1;
        dly[i] = (maxd == 0) ? 0 : int'($urandom_range(0, maxd));
      end
    end
    co = (ctr == NR - 1);
  end

  task automatic run_msg(input int d, output bit to, output int lat);
    int t0;
    clear_model(1'b0);
    maxd = d;
    @(negedge clk); #1;
    start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk); #1;
    start = 1'b0;
    to = 1'b1;
    lat = -1;
    for (int k = 0; k < 6000; k++) begin
      if (n_done != 0) begin
        to = 1'b0;
        lat = done_cyc - t0;
        break;
      end
      @(negedge clk); #1;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({start_par, start_rot, start_per, start_rev, start_RC,
         cnt_up, busy, done, err} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0",
               {start_par, start_rot, start_per, start_rev,
                start_RC, cnt_up, busy, done, err});
    end
    checks++;
    if (round !== 5'd0) begin
      errors++;
      $display("FAIL reset_round: got %0d want 0", round);
    end
    rst = 1'b1;
    clear_model(1'b1);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b want 0 0",
               busy, done);
    end
  endtask

  task automatic test_nominal();
    bit to;
    int lat;
    run_msg(0, to, lat);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL nominal_timeout: done not seen, want done");
    end
    checks++;
    if (lat !== 240) begin
      errors++;
      $display("FAIL nominal_latency: got %0d want 240", lat);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (n_start[i] !== NR) begin
        errors++;
        $display("FAIL nominal_starts[%0d]: got %0d want %0d",
                 i, n_start[i], NR);
      end
    end
    checks++;
    if (n_cntup !== NR || n_done !== 1) begin
      errors++;
      $display("FAIL nominal_counts: cnt_up=%0d done=%0d want %0d 1",
               n_cntup, n_done, NR);
    end
    checks++;
    if (order_err + rdy_err + round_err + cntup_err !== 0) begin
      errors++;
      $display("FAIL nominal_protocol: ord=%0d rdy=%0d rnd=%0d cu=%0d want 0",
               order_err, rdy_err, round_err, cntup_err);
    end
    checks++;
    if (busy !== 1'b0 || round !== 5'd0 || ctr !== 0) begin
      errors++;
      $display("FAIL nominal_end: busy=%b round=%0d ctr=%0d want 0 0 0",
               busy, round, ctr);
    end
  endtask

  task automatic test_ignore_ready();
    bit to;
    int lat;
    hold_rot = 1'b1;
    run_msg(0, to, lat);
    hold_rot = 1'b0;
    checks++;
    if (to || lat !== 240) begin
      errors++;
      $display("FAIL hold_rot_latency: to=%b lat=%0d want 0 240", to, lat);
    end
    checks++;
    if (n_start[1] !== NR || rdy_err !== 0 || order_err !== 0) begin
      errors++;
      $display("FAIL hold_rot_order: rot=%0d rdy=%0d ord=%0d want %0d 0 0",
               n_start[1], rdy_err, order_err, NR);
    end
  endtask

  task automatic test_start_busy();
    bit to;
    int lat;
    clear_model(1'b0);
    maxd = 0;
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (round == 5'd5) begin to = 1'b0; break; end
      @(negedge clk); #1;
    end
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 400 && !to; k++) begin
      if (n_done != 0) break;
      if (k == 399) to = 1'b1;
      @(negedge clk); #1;
    end
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (to) begin
      errors++;
      $display("FAIL busy_start_timeout: run stalled, want done");
    end
    checks++;
    if (busy !== 1'b0 || n_done !== 1 || n_start[0] !== NR) begin
      errors++;
      $display("FAIL busy_start_ignored: busy=%b done=%0d par=%0d want 0 1 %0d",
               busy, n_done, n_start[0], NR);
    end
    run_msg(0, to, lat);
    checks++;
    if (to || lat !== 240 || n_cntup !== NR || round_err !== 0) begin
      errors++;
      $display("FAIL second_msg: to=%b lat=%0d cu=%0d rnd=%0d want 0 240 %0d 0",
               to, lat, n_cntup, round_err, NR);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    bit hit;
    int lat;
    clear_model(1'b0);
    maxd = 0;
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (round == 5'd10 && start_rev) begin hit = 1'b1; break; end
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach: REV_W of round 10 not reached");
    end
    checks++;
    if ({start_par, start_rot, start_per, start_rev, start_RC,
         cnt_up, busy, done, err, round} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b want 0",
               {start_par, start_rot, start_per, start_rev, start_RC,
                cnt_up, busy, done, err, round});
    end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    clear_model(1'b1);
    run_msg(0, to, lat);
    checks++;
    if (to || lat !== 240 || n_start[0] !== NR || round_err !== 0 ||
        order_err !== 0) begin
      errors++;
      $display("FAIL reset_mid_rerun: to=%b lat=%0d par=%0d rnd=%0d ord=%0d",
               to, lat, n_start[0], round_err, order_err);
    end
  endtask

  task automatic test_random();
    bit to;
    int lat;
    for (int m = 0; m < 3; m++) begin
      run_msg(20, to, lat);
      checks++;
      if (to || n_done !== 1 || n_cntup !== NR) begin
        errors++;
        $display("FAIL random_msg%0d: to=%b done=%0d cu=%0d want 0 1 %0d",
                 m, to, n_done, n_cntup, NR);
      end
      checks++;
      if (order_err + rdy_err + round_err + cntup_err !== 0 ||
          n_start[4] !== NR) begin
        errors++;
        $display("FAIL random_proto%0d: ord=%0d rdy=%0d rnd=%0d cu=%0d rc=%0d",
                 m, order_err, rdy_err, round_err, cntup_err, n_start[4]);
      end
    end
  endtask

`ifdef STEP_WDOG_EN
  task automatic test_watchdog();
    int err_cyc;
    clear_model(1'b0);
    maxd = 0;
    block_per = 1'b1;
    err_cyc = -1;
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (err && err_cyc < 0) err_cyc = cyc;
      if (!busy) break;
      @(negedge clk); #1;
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || err_cyc - per_cyc !== 65) begin
      errors++;
      $display("FAIL wdog_timeout: err=%b busy=%b dt=%0d want 1 0 65",
               err, busy, err_cyc - per_cyc);
    end
    block_per = 1'b0;
    clear_model(1'b1);
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wdog_clear: err=%b busy=%b want 0 1", err, busy);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    clear_model(1'b1);
  endtask
`endif

  initial begin
    clear_model(1'b1);
    test_reset();
    test_nominal();
    test_ignore_ready();
    test_start_busy();
    test_reset_mid();
    test_random();
`ifdef STEP_WDOG_EN
    test_watchdog();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
